coin_toss_serializer: RTL

Serial coin-toss source that drives the single-bit toss stream consumed by the consecutive-heads Moore detector (1 = head, 0 = tail).
- Accepts one burst request per valid/ready handshake.
- Each burst is either a parallel word shifted out MSB-first, or a counted run of pseudo-random tosses from an internal LFSR.
- Sits upstream of the detector in the coin-toss subsystem and in the self-checking bench.

---
 rtl/coin_toss_pkg.sv | 22 ++
 rtl/coin_toss_serializer_if.sv | 29 ++
 rtl/coin_toss_serializer_lfsr.sv | 29 ++
 rtl/coin_toss_serializer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/coin_toss_pkg.sv
// Shared definitions for the coin-toss subsystem: serializer FSM encodings
// and the LFSR polynomial/seed used by the random toss source.
package coin_toss_pkg;

    // One-hot serializer states; any other encoding is treated as illegal.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'b0001,
        ST_SHIFT_WORD = 4'b0010,
        ST_SHIFT_RAND = 4'b0100,
        ST_DONE       = 4'b1000
    } toss_state_e;

    // Galois mask for x^16+x^14+x^13+x^11+1, right-shifting form.
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/coin_toss_serializer_if.sv
// Burst request / toss stream bundle between a requester and the serializer.
// Handshake: a request transfers on a rising clock edge where load_valid and
// load_ready are both high; load_ready never depends on load_valid, and the
// requester keeps load_mode/word/count stable while load_valid waits.
interface coin_toss_serializer_if #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8
);
    logic              load_valid;
    logic              load_ready;
    logic              load_mode;
    logic [WORD_W-1:0] load_word;
    logic [CNT_W-1:0]  load_count;
    logic              sequence_out;
    logic              sequence_valid;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  heads_count;

    modport master (
        output load_valid, load_mode, load_word, load_count,
        input  load_ready, sequence_out, sequence_valid, busy, done, heads_count
    );

    modport slave (
        input  load_valid, load_mode, load_word, load_count,
        output load_ready, sequence_out, sequence_valid, busy, done, heads_count
    );
endinterface

// File: rtl/coin_toss_serializer_lfsr.sv
// 16-bit right-shifting Galois LFSR. A zero seed would lock up the register,
// so it is replaced by 16'h0001.
module coin_lfsr16
    import coin_toss_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic        bit_out
);
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] seed_eff;

    assign seed_eff = (seed == 16'h0000) ? 16'h0001 : seed;
    assign bit_out  = lfsr_q[0];

    // Step the register only when the consumer takes the current bit.
    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) lfsr_d = lfsr_step(lfsr_q);
    end

    // State register; only reset reloads the seed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) lfsr_q <= seed_eff;
        else        lfsr_q <= lfsr_d;
    end
endmodule

// File: rtl/coin_toss_serializer.sv
// Coin-toss serializer: accepts a burst request and emits either a parallel
// word MSB-first or a counted run of LFSR tosses, one toss per cycle, with
// registered outputs, a done pulse and a running heads count.
module coin_toss_serializer
    import coin_toss_pkg::*;
#(
    parameter int          WORD_W    = 8,
    parameter int          CNT_W     = 8,
    parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
    input  logic                   clock,
    input  logic                   reset,
    coin_toss_serializer_if.slave  bus,
    output logic [3:0]             state_dbg
);
    // Remaining-toss counter must hold both WORD_W-1 and load_count-1.
    localparam int RW = (CNT_W > $clog2(WORD_W)) ? CNT_W : $clog2(WORD_W);

    toss_state_e       state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic              seq_out_q, seq_out_d;
    logic              seq_valid_q, seq_valid_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  heads_q, heads_d;
    logic              lfsr_advance;
    logic              lfsr_bit;

    // The LFSR steps each time one of its bits is latched into sequence_out,
    // so it advances exactly once per random toss and persists across bursts.
    coin_lfsr16 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .advance (lfsr_advance),
        .seed    (LFSR_SEED),
        .bit_out (lfsr_bit)
    );

    assign bus.load_ready     = (state_q == ST_IDLE);
    assign bus.busy           = (state_q == ST_SHIFT_WORD) || (state_q == ST_SHIFT_RAND) ||
                                (state_q == ST_DONE);
    assign bus.sequence_out   = seq_out_q;
    assign bus.sequence_valid = seq_valid_q;
    assign bus.done           = done_q;
    assign bus.heads_count    = heads_q;
    assign state_dbg          = state_q;

    // Next-state and next-output logic; each toss is staged one cycle ahead
    // so the registered outputs line up with the SHIFT states.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        rem_d        = rem_q;
        seq_out_d    = 1'b0;
        seq_valid_d  = 1'b0;
        done_d       = 1'b0;
        heads_d      = heads_q;
        lfsr_advance = 1'b0;

        // Count the head currently on the output, saturating.
        if (seq_valid_q && seq_out_q && (heads_q != '1)) heads_d = heads_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (bus.load_valid) begin
                    heads_d = '0;
                    if (!bus.load_mode) begin
                        state_d     = ST_SHIFT_WORD;
                        seq_out_d   = bus.load_word[WORD_W-1];
                        seq_valid_d = 1'b1;
                        shift_d     = bus.load_word << 1;
                        rem_d       = RW'(WORD_W - 1);
                    end else if (bus.load_count == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = ST_SHIFT_RAND;
                        seq_out_d    = lfsr_bit;
                        seq_valid_d  = 1'b1;
                        lfsr_advance = 1'b1;
                        rem_d        = RW'(bus.load_count) - RW'(1);
                    end
                end
            end
            ST_SHIFT_WORD: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    seq_out_d   = shift_q[WORD_W-1];
                    seq_valid_d = 1'b1;
                    shift_d     = shift_q << 1;
                    rem_d       = rem_q - RW'(1);
                end
            end
            ST_SHIFT_RAND: begin
                if (rem_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    seq_out_d    = lfsr_bit;
                    seq_valid_d  = 1'b1;
                    lfsr_advance = 1'b1;
                    rem_d        = rem_q - RW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All serializer state, cleared asynchronously so a burst is abandoned.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            rem_q       <= '0;
            seq_out_q   <= 1'b0;
            seq_valid_q <= 1'b0;
            done_q      <= 1'b0;
            heads_q     <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            rem_q       <= rem_d;
            seq_out_q   <= seq_out_d;
            seq_valid_q <= seq_valid_d;
            done_q      <= done_d;
            heads_q     <= heads_d;
        end
    end
endmodule
